interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer_pkg.sv | 29 ++
 rtl/interval_timer.sv | 101 ++++++++++
 tb/tb_interval_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/interval_timer_pkg.sv
// Shared register map, CTRL field positions, mode codes and FSM encoding for the interval timer.
package interval_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_UNUSED = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Codes 10/11 behave as one-shot, so only the exact auto code reloads.
  function automatic logic is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Memory-mapped down-counting timer: IRQ rises PRESET+3 edges after Enable is written.
// Reads are combinational and reflect pre-edge state; writes always accepted.
module interval_timer
  import interval_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state;

  logic ctrl_wr;
  logic preset_wr;
  logic enable;
  logic auto_mode;

  assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
  assign preset_wr = WE && (Addr == ADDR_PRESET);
  assign enable    = ctrl[CTRL_EN];
  assign auto_mode = is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= 4'h0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (preset_wr)
        preset <= Din;

      // A CPU write to CTRL beats the hardware Enable clear on the same edge.
      if (ctrl_wr)
        ctrl <= Din[3:0];
      else if (state == ST_INT && !auto_mode)
        ctrl[CTRL_EN] <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (count != 32'h0) begin
            count <= count - 32'h1;
          end else begin
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (auto_mode) begin
            irq_flag <= 1'b0;
            state    <= enable ? ST_LOAD : ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // One-shot acknowledge: any CTRL write drops the sticky flag.
      if (ctrl_wr && !auto_mode)
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'h0;
    case (Addr)
      ADDR_CTRL:   Dout = {28'h0, ctrl};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      ADDR_UNUSED: Dout = 32'h0;
      default:     Dout = 32'h0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_interval_timer.sv
// Directed-vector bench for interval_timer; edge numbers count from the CTRL write edge.
module tb_interval_timer;
  import interval_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_tests = 0;
  int n_fail  = 0;

  interval_timer dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick(1);
    WE   = 1'b0;
    Din  = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = Dout;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b0; Addr = 2'd0; WE = 1'b0; Din = 32'h0;
    tick(1);

    // Reset state
    do_reset();
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    rd(ADDR_CTRL, v);   chk("rst_ctrl", v, 32'h0);
    rd(ADDR_PRESET, v); chk("rst_preset", v, 32'h0);
    rd(ADDR_COUNT, v);  chk("rst_count", v, 32'h0);

    // One-shot, PRESET=5, IM set
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    tick(2); rd(ADDR_COUNT, v); chk("os_count_e2", v, 32'd5);
    tick(5); rd(ADDR_COUNT, v); chk("os_count_e7", v, 32'd0);
    chk("os_irq_e7", {31'h0, IRQ}, 32'h0);
    tick(1); chk("os_irq_e8", {31'h0, IRQ}, 32'h1);
    tick(3); chk("os_irq_held", {31'h0, IRQ}, 32'h1);
    rd(ADDR_CTRL, v); chk("os_ctrl_en_clr", v, 32'h8);
    wr(ADDR_CTRL, 32'h8);
    chk("os_ack_irq", {31'h0, IRQ}, 32'h0);

    // Auto-reload, PRESET=3: pulses after edges 6, 12, 18
    do_reset();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("ar_irq_e%0d", k), {31'h0, IRQ}, 32'((k == 6) || (k == 12) || (k == 18)));
    end

    // IM=0: flag sets but IRQ stays low
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      chk($sformatf("im0_irq_e%0d", k), {31'h0, IRQ}, 32'h0);
    end
    chk("im0_flag_e13", {31'h0, dut.irq_flag}, 32'h1);
    tick(2); rd(ADDR_CTRL, v); chk("im0_ctrl", v, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    chk("im0_flag_ack", {31'h0, dut.irq_flag}, 32'h0);
    chk("im0_irq_ack", {31'h0, IRQ}, 32'h0);

    // Disable mid-count freezes COUNT
    do_reset();
    wr(ADDR_PRESET, 32'd8);
    wr(ADDR_CTRL, 32'h1);
    tick(6); rd(ADDR_COUNT, v); chk("dis_count4", v, 32'd4);
    wr(ADDR_CTRL, 32'h0);
    rd(ADDR_COUNT, v); chk("dis_count3", v, 32'd3);
    tick(1); chk("dis_state", 32'(dut.state), 32'(ST_IDLE));
    rd(ADDR_COUNT, v); chk("dis_frozen1", v, 32'd3);
    tick(3); rd(ADDR_COUNT, v); chk("dis_frozen2", v, 32'd3);

    // PRESET write mid-count only takes effect at reload
    do_reset();
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'h3);
    tick(3);
    wr(ADDR_PRESET, 32'd9);
    rd(ADDR_COUNT, v);  chk("pw_count_e4", v, 32'd2);
    rd(ADDR_PRESET, v); chk("pw_preset", v, 32'd9);
    tick(5); rd(ADDR_COUNT, v); chk("pw_reload_e9", v, 32'd9);

    // Reset while in INT, with a competing CTRL write
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    tick(5); chk("ri_irq_e5", {31'h0, IRQ}, 32'h1);
    rst = 1'b1; Addr = ADDR_CTRL; Din = 32'h9; WE = 1'b1;
    tick(1);
    rst = 1'b0; WE = 1'b0; Din = 32'h0;
    chk("ri_irq", {31'h0, IRQ}, 32'h0);
    chk("ri_state", 32'(dut.state), 32'(ST_IDLE));
    rd(ADDR_CTRL, v);   chk("ri_ctrl", v, 32'h0);
    rd(ADDR_PRESET, v); chk("ri_preset", v, 32'h0);
    rd(ADDR_COUNT, v);  chk("ri_count", v, 32'h0);
    tick(2); chk("ri_state_hold", 32'(dut.state), 32'(ST_IDLE));
    wr(ADDR_COUNT, 32'h1234);
    rd(ADDR_COUNT, v); chk("ro_count", v, 32'h0);
    wr(ADDR_UNUSED, 32'hFFFF_FFFF);
    rd(ADDR_UNUSED, v); chk("ro_addr3", v, 32'h0);
    rd(ADDR_CTRL, v);   chk("ro_ctrl", v, 32'h0);

    // PRESET=0 reaches INT one edge after LOAD
    do_reset();
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    tick(2); chk("p0_irq_e2", {31'h0, IRQ}, 32'h0);
    tick(1); chk("p0_irq_e3", {31'h0, IRQ}, 32'h1);

    // Mode 10 behaves as one-shot
    do_reset();
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'hD);
    tick(3); chk("m2_irq_e3", {31'h0, IRQ}, 32'h0);
    tick(1); chk("m2_irq_e4", {31'h0, IRQ}, 32'h1);
    tick(3); chk("m2_irq_held", {31'h0, IRQ}, 32'h1);
    rd(ADDR_CTRL, v); chk("m2_ctrl", v, 32'hC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
